// File: rtl/cpu_mul_pipe_if.sv
// Issue and register-bank writeback bundle for the pipelined multiplier.
// The in_high select exists only when CPU_MUL_HIGH_EN is defined.
interface cpu_mul_pipe_if #(
   parameter int REG_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

   logic                      in_valid;
   logic [REG_ADDR_WIDTH-1:0] in_rd;
   logic [REG_WIDTH-1:0]      in_op_a;
   logic [REG_WIDTH-1:0]      in_op_b;
`ifdef CPU_MUL_HIGH_EN
   logic                      in_high;
`endif
   logic                      flush;
   logic                      write_enable_mul;
   logic [REG_ADDR_WIDTH-1:0] write_reg_mul;
   logic [REG_WIDTH-1:0]      write_data_mul;
   logic [NUM_REGS-1:0]       pending_mask;
   logic                      busy;

   modport master (
      output in_valid, in_rd, in_op_a, in_op_b,
`ifdef CPU_MUL_HIGH_EN
      output in_high,
`endif
      output flush,
      input  write_enable_mul, write_reg_mul, write_data_mul, pending_mask, busy
   );

   modport slave (
      input  in_valid, in_rd, in_op_a, in_op_b,
`ifdef CPU_MUL_HIGH_EN
      input  in_high,
`endif
      input  flush,
      output write_enable_mul, write_reg_mul, write_data_mul, pending_mask, busy
   );
endinterface

// File: rtl/cpu_mul_pipe.sv
// Fixed-latency pipelined integer multiplier feeding the register bank's multiply port.
// Optional CPU_MUL_HIGH_EN adds in_high to return the signed upper product half (MULH).
module cpu_mul_pipe #(
   parameter int REG_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MUL_STAGES     = 5
) (
   input  logic          clock,
   input  logic          reset,
   cpu_mul_pipe_if.slave bus
);
   localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
   localparam int LAST     = MUL_STAGES - 1;

   if (MUL_STAGES < 2 || MUL_STAGES > 8) begin : g_bad_depth
      $error("cpu_mul_pipe: MUL_STAGES must be within 2..8");
   end

`ifdef CPU_MUL_HIGH_EN
   function automatic logic [REG_WIDTH-1:0] mul_result(
      input logic signed [REG_WIDTH-1:0] a,
      input logic signed [REG_WIDTH-1:0] b,
      input logic                        high
   );
      logic signed [2*REG_WIDTH-1:0] full;
      full = (2*REG_WIDTH)'(a) * (2*REG_WIDTH)'(b);
      return high ? full[2*REG_WIDTH-1:REG_WIDTH] : full[REG_WIDTH-1:0];
   endfunction
`else
   function automatic logic [REG_WIDTH-1:0] mul_result(
      input logic signed [REG_WIDTH-1:0] a,
      input logic signed [REG_WIDTH-1:0] b
   );
      logic signed [REG_WIDTH-1:0] low;
      low = a * b;
      return low;
   endfunction
`endif

   // vld_p[0] is the operand slice, vld_p[LAST] the output slice
   logic [MUL_STAGES-1:0]        vld_p;
   logic [REG_ADDR_WIDTH-1:0]    rd_p0;
   logic signed [REG_WIDTH-1:0]  op_a_p0;
   logic signed [REG_WIDTH-1:0]  op_b_p0;
`ifdef CPU_MUL_HIGH_EN
   logic                         high_p0;
`endif
   logic [REG_ADDR_WIDTH-1:0]    rd_p  [1:LAST];
   logic signed [REG_WIDTH-1:0]  res_p [1:LAST];
   logic [NUM_REGS-1:0]          pend;

   // Flush and reset both empty every slice; an op on the outputs this cycle is already committed
   always_ff @(posedge clock) begin
      if (reset || bus.flush) begin
         vld_p <= '0;
      end else begin
         vld_p <= {vld_p[MUL_STAGES-2:0], bus.in_valid};
      end
   end

   // ---- stage p0: capture operands ----
   // ---- stage p1: full product; later slices only carry the result ----
   always_ff @(posedge clock) begin
      if (bus.in_valid) begin
         rd_p0   <= bus.in_rd;
         op_a_p0 <= bus.in_op_a;
         op_b_p0 <= bus.in_op_b;
`ifdef CPU_MUL_HIGH_EN
         high_p0 <= bus.in_high;
`endif
      end
      if (vld_p[0] && !(LAST == 1 && bus.flush)) begin
         rd_p[1]  <= rd_p0;
`ifdef CPU_MUL_HIGH_EN
         res_p[1] <= mul_result(op_a_p0, op_b_p0, high_p0);
`else
         res_p[1] <= mul_result(op_a_p0, op_b_p0);
`endif
      end
      for (int s = 2; s <= LAST; s++) begin
         // The output slice keeps its last value when the incoming op is flushed
         if (vld_p[s-1] && !(s == LAST && bus.flush)) begin
            rd_p[s]  <= rd_p[s-1];
            res_p[s] <= res_p[s-1];
         end
      end
      if (reset) begin
         rd_p[LAST]  <= '0;
         res_p[LAST] <= '0;
      end
   end

   always_comb begin
      pend = '0;
      if (vld_p[0]) pend[rd_p0] = 1'b1;
      for (int s = 1; s < LAST; s++) begin
         if (vld_p[s]) pend[rd_p[s]] = 1'b1;
      end
   end

   assign bus.write_enable_mul = vld_p[LAST];
   assign bus.write_reg_mul    = rd_p[LAST];
   assign bus.write_data_mul   = res_p[LAST];
   assign bus.pending_mask     = pend;
   assign bus.busy             = |vld_p;
endmodule

// File: tb/tb_cpu_mul_pipe.sv
// Bench for cpu_mul_pipe: directed scenarios then random traffic, checked each cycle
// against a history-based model of issue, kill and writeback timing.
module tb_cpu_mul_pipe;
   localparam int RW   = 32;
   localparam int AW   = 5;
   localparam int NR   = 32;
   localparam int S    = 5;
   localparam int MAXC = 1024;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   cpu_mul_pipe_if #(.REG_WIDTH(RW), .REG_ADDR_WIDTH(AW)) bus ();

   cpu_mul_pipe #(.REG_WIDTH(RW), .REG_ADDR_WIDTH(AW), .MUL_STAGES(S)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   bit            h_v    [MAXC];
   bit            h_hi   [MAXC];
   bit            h_kill [MAXC];
   bit            h_rst  [MAXC];
   logic [AW-1:0] h_rd   [MAXC];
   logic [RW-1:0] h_a    [MAXC];
   logic [RW-1:0] h_b    [MAXC];
   int            cyc      = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [AW-1:0] last_reg  = '0;
   logic [RW-1:0] last_data = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] ref_result(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                                input bit hi);
      logic signed [63:0] sp;
      logic [63:0]        up;
      if (hi) begin
         sp = 64'($signed(a)) * 64'($signed(b));
         return sp[63:32];
      end
      up = 64'(a) * 64'(b);
      return up[31:0];
   endfunction

   // An op issued in cycle j is gone if any flush/reset was sampled in cycles j..c-1
   function automatic bit killed(input int j, input int c);
      for (int f = j; f < c; f++) if (h_kill[f]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_cycle(input int c);
      logic          we_e;
      logic          busy_e;
      logic [NR-1:0] pend_e;
      we_e = 1'b0; busy_e = 1'b0; pend_e = '0;
      if (h_rst[c-1]) begin
         last_reg  = '0;
         last_data = '0;
      end
      for (int j = c - S; j < c; j++) begin
         if (j >= 0 && h_v[j] && !killed(j, c)) begin
            busy_e = 1'b1;
            if (c - j < S) begin
               pend_e[h_rd[j]] = 1'b1;
            end else begin
               we_e      = 1'b1;
               last_reg  = h_rd[j];
               last_data = ref_result(h_a[j], h_b[j], h_hi[j]);
            end
         end
      end
      check("write_enable", bus.write_enable_mul, we_e);
      check("pending_mask", bus.pending_mask, pend_e);
      check("busy", bus.busy, busy_e);
      check("write_reg", bus.write_reg_mul, last_reg);
      check("write_data", bus.write_data_mul, last_data);
   endtask

   task automatic step(input bit v, input logic [AW-1:0] rd, input logic [RW-1:0] a,
                       input logic [RW-1:0] b, input bit hi, input bit fl, input bit rs);
      @(posedge clock);
      #1;
      bus.in_valid = v;
      bus.in_rd    = rd;
      bus.in_op_a  = a;
      bus.in_op_b  = b;
`ifdef CPU_MUL_HIGH_EN
      bus.in_high  = hi;
      h_hi[cyc]    = hi;
`else
      h_hi[cyc]    = 1'b0;
`endif
      bus.flush    = fl;
      reset        = rs;
      h_v[cyc]     = v;
      h_rd[cyc]    = rd;
      h_a[cyc]     = a;
      h_b[cyc]     = b;
      h_kill[cyc]  = fl | rs;
      h_rst[cyc]   = rs;
      @(negedge clock);
      if (cyc >= 1) check_cycle(cyc);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, AW'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [RW-1:0] a;
      logic [RW-1:0] b;
      logic [AW-1:0] rd;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_rd    = '0;
      bus.in_op_a  = '0;
      bus.in_op_b  = '0;
      bus.flush    = 1'b0;
`ifdef CPU_MUL_HIGH_EN
      bus.in_high  = 1'b0;
`endif
      step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);

      // single op 7*6 -> r3
      step(1'b1, 5'd3, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
      idle(6);

      // back-to-back r1..r5
      for (int r = 1; r <= 5; r++) step(1'b1, AW'(r), RW'(r), 32'd10, 1'b0, 1'b0, 1'b0);
      idle(6);

      // overflow wrap, and the upper half when the high select is present
      step(1'b1, 5'd9,  32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd10, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0);
      idle(6);

      // flush in cycle 4 after issues in cycles 0..2
      step(1'b1, 5'd11, 32'd11, 32'd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd12, 32'd12, 32'd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd13, 32'd13, 32'd3, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 5'd14, 32'd14, 32'd3, 1'b0, 1'b1, 1'b0);
      idle(6);

      // reset one cycle after an issue
      idle(2);
      step(1'b1, 5'd15, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      idle(7);

      // WAW to r7
      step(1'b1, 5'd7, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd7, 32'd9, 32'd1, 1'b0, 1'b0, 1'b0);
      idle(6);

      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'hFFFF_FFFF;
            1: b = 32'h8000_0000;
            2: a = '0;
            default: ;
         endcase
         rd = (i % 100 < 50) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         step($urandom_range(0, 9) < 7, rd, a, b, 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
      end
      idle(S + 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
